// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter and the data memory:
// FSM state encoding, requester port ids and load/store size codes.
package dmem_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Requester ids; also the bit positions inside 2-bit req/gnt vectors.
  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // funct3 size/sign codes understood by the data memory.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester always wins; on a
// conflict the port that did not win last time is chosen.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  assign o_gnt[PORT_C] = i_req[PORT_C] & (~i_req[PORT_D] | (i_last == PORT_D));
  assign o_gnt[PORT_D] = i_req[PORT_D] & (~i_req[PORT_C] | (i_last == PORT_C));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store path (C) and a debug /
// loader master (D). Round-robin grant, bounded debug lock, read-return
// tagging. Optional build macro DMEM_ARB_STATS_EN adds conflict_cnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic [2:0]    core_funct3,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic [2:0]    dbg_funct3,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_broken
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  arb_state_t r_state, w_state_nxt;
  logic       r_last_grant, w_last_nxt;
  logic [7:0] r_lock_cnt, w_lock_cnt_nxt;
  logic       r_lock_armed, w_lock_armed_nxt;
  logic       r_lock_broken, w_break;
  logic       r_rd_tag_valid, r_rd_tag;
  logic [1:0] w_req, w_pick;
  logic       w_core_gnt, w_dbg_gnt;

  // Under lock the core is simply hidden from the picker.
  assign w_req = {dbg_req, core_req & (r_state == ARB)};

  rr_arb2 u_rr (
    .i_req  (w_req),
    .i_last (r_last_grant),
    .o_gnt  (w_pick)
  );

  assign w_core_gnt = w_pick[PORT_C] & ~reset;
  assign w_dbg_gnt  = w_pick[PORT_D] & ~reset;
  assign core_gnt   = w_core_gnt;
  assign dbg_gnt    = w_dbg_gnt;
  assign core_stall = core_req & ~w_core_gnt;
  assign mem_en     = w_core_gnt | w_dbg_gnt;

  // Next-state logic for the ARB/LOCK FSM, lock counter and round-robin history.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt      = r_state;
    w_last_nxt       = r_last_grant;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_lock_armed_nxt = r_lock_armed | ~dbg_lock;
    w_break          = 1'b0;
    case (r_state)
      ARB: begin
        w_lock_cnt_nxt = '0;
        if (w_core_gnt) w_last_nxt = PORT_C;
        if (w_dbg_gnt)  w_last_nxt = PORT_D;
        if (w_dbg_gnt && dbg_lock && r_lock_armed) begin
          w_state_nxt    = LOCK;
          w_lock_cnt_nxt = 8'd1;
        end
      end
      LOCK: begin
        // Leaving LOCK always hands the next conflict to the core.
        w_last_nxt     = PORT_D;
        w_lock_cnt_nxt = (r_lock_cnt == 8'hFF) ? r_lock_cnt : r_lock_cnt + 8'd1;
        if (!dbg_lock) begin
          w_state_nxt = ARB;
        end else if (r_lock_cnt == 8'(MAX_LOCK)) begin
          w_state_nxt      = ARB;
          w_break          = 1'b1;
          w_lock_armed_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // State registers; last_grant resets to D so the core wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state        <= ARB;
      r_last_grant   <= PORT_D;
      r_lock_cnt     <= '0;
      r_lock_armed   <= 1'b1;
      r_lock_broken  <= 1'b0;
      r_rd_tag_valid <= 1'b0;
      r_rd_tag       <= PORT_C;
    end else begin
      r_state        <= w_state_nxt;
      r_last_grant   <= w_last_nxt;
      r_lock_cnt     <= w_lock_cnt_nxt;
      r_lock_armed   <= w_lock_armed_nxt;
      r_lock_broken  <= w_break;
      r_rd_tag_valid <= (w_core_gnt & ~core_we) | (w_dbg_gnt & ~dbg_we);
      r_rd_tag       <= w_dbg_gnt ? PORT_D : PORT_C;
    end
  end

  assign lock_broken = r_lock_broken;

  // Memory request mux from the granted port; idle bus drives zeros.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (w_core_gnt) begin
      mem_we     = core_we;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      mem_funct3 = core_funct3;
    end else if (w_dbg_gnt) begin
      mem_we     = dbg_we;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_funct3 = dbg_funct3;
    end
  end

  assign core_rvalid = r_rd_tag_valid & (r_rd_tag == PORT_C);
  assign dbg_rvalid  = r_rd_tag_valid & (r_rd_tag == PORT_D);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  // Saturating count of cycles the core waited for the memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_conflict_cnt <= '0;
    else if (core_stall && r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MAX_LOCK = 16).
// Inputs change just after the falling edge and outputs are sampled 1 ns later.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic [2:0]    core_funct3;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [2:0]    dbg_funct3;
  logic          mem_en, mem_we, lock_broken;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    mem_funct3;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(16)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_funct3(dbg_funct3), .dbg_lock(dbg_lock),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .lock_broken(lock_broken)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Next cycle's inputs (applied after the falling edge), then settle 1 ns.
  task automatic cyc(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                     input logic d_req, input logic d_we, input logic [31:0] d_addr,
                     input logic d_lock, input logic [31:0] rdata);
    @(negedge clk);
    core_req = c_req; core_we = c_we; core_addr = c_addr;
    core_wdata = c_addr ^ 32'hA5A5_0000; core_funct3 = c_we ? SW : LW;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr;
    dbg_wdata = d_addr ^ 32'h5A5A_0000; dbg_funct3 = d_we ? SB : LBU;
    dbg_lock = d_lock; mem_rdata = rdata;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1, 0, 32'h40, 1, 0, 32'h44, 1, 0);
    n_checks++;
    if ({core_gnt, dbg_gnt, mem_en, core_rvalid, dbg_rvalid, lock_broken} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {core_gnt, dbg_gnt, mem_en, core_rvalid, dbg_rvalid, lock_broken});
    end
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({mem_en, mem_addr, mem_wdata, mem_funct3} !== '0) begin
      n_fail++;
      $display("FAIL idle_bus: en=%b addr=%h wdata=%h f3=%h expected all 0",
               mem_en, mem_addr, mem_wdata, mem_funct3);
    end
  endtask

  task automatic test_core_load();
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
    n_checks++;
    if ({core_gnt, dbg_gnt, core_stall, mem_en, mem_we} !== 5'b10010 ||
        mem_addr !== 32'h10 || mem_funct3 !== LW) begin
      n_fail++;
      $display("FAIL core_load_gnt: gnt/dgnt/stall/en/we=%b addr=%h f3=%h expected 10010 00000010 2",
               {core_gnt, dbg_gnt, core_stall, mem_en, mem_we}, mem_addr, mem_funct3);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
    n_checks++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEAD_BEEF || dbg_rvalid !== 1'b0 ||
        dbg_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL core_load_data: crv=%b crd=%h drv=%b drd=%h expected 1 deadbeef 0 0",
               core_rvalid, core_rdata, dbg_rvalid, dbg_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_core_gnt;
    logic [3:0] got_core_gnt, got_dbg_gnt, got_stall;
    logic [2:0] got_crv;
    exp_core_gnt = 4'b0101;  // bit i = cycle i: C, D, C, D
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h100 + i, 1, 0, 32'h200 + i, 0, 32'h0);
      got_core_gnt[i] = core_gnt;
      got_dbg_gnt[i]  = dbg_gnt;
      got_stall[i]    = core_stall;
      if (i > 0) got_crv[i-1] = core_rvalid;
    end
    n_checks++;
    if (got_core_gnt !== exp_core_gnt || got_dbg_gnt !== ~exp_core_gnt) begin
      n_fail++;
      $display("FAIL rr_grants: core=%b dbg=%b expected core=0101 dbg=1010",
               got_core_gnt, got_dbg_gnt);
    end
    n_checks++;
    if (got_stall !== 4'b1010) begin
      n_fail++;
      $display("FAIL rr_stall: got %b expected 1010", got_stall);
    end
    n_checks++;
    if (got_crv !== 3'b101) begin
      n_fail++;
      $display("FAIL rr_rvalid_route: core_rvalid cycles1..3=%b expected 101", got_crv);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 32'h0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 32'h4, 0, 32'h11);
    n_checks++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'h11 || dbg_gnt !== 1'b1 ||
        dbg_rvalid !== 1'b0 || mem_addr !== 32'h4 || mem_funct3 !== LBU) begin
      n_fail++;
      $display("FAIL b2b_first: crv=%b crd=%h dgnt=%b drv=%b addr=%h f3=%h expected 1 11 1 0 4 4",
               core_rvalid, core_rdata, dbg_gnt, dbg_rvalid, mem_addr, mem_funct3);
    end
    cyc(1, 1, 32'h8, 0, 0, 0, 0, 32'h22);
    n_checks++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h22 || core_rvalid !== 1'b0 ||
        core_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_second: drv=%b drd=%h crv=%b crd=%h expected 1 22 0 0",
               dbg_rvalid, dbg_rdata, core_rvalid, core_rdata);
    end
    n_checks++;
    if (mem_we !== 1'b1 || mem_wdata !== (32'h8 ^ 32'hA5A5_0000) || mem_funct3 !== SW) begin
      n_fail++;
      $display("FAIL core_write: we=%b wdata=%h f3=%h expected 1 a5a50008 2",
               mem_we, mem_wdata, mem_funct3);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h33);
    n_checks++;
    if ({core_rvalid, dbg_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL write_no_rvalid: got %b expected 00", {core_rvalid, dbg_rvalid});
    end
  endtask

  task automatic test_lock();
    int blocked, bad_lock, bad_alt;
    logic exp_c;
    blocked = 0; bad_lock = 0; bad_alt = 0;
    do_reset();
    cyc(0, 0, 0, 1, 1, 32'h300, 1, 0);   // debug wins and takes the lock
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 32'h50, 1, 1, 32'h300 + i, 1, 0);
      if (core_stall === 1'b1) blocked++;
      if (core_gnt !== 1'b0 || dbg_gnt !== 1'b1 || lock_broken !== 1'b0) bad_lock++;
    end
    n_checks++;
    if (blocked !== 16 || bad_lock !== 0) begin
      n_fail++;
      $display("FAIL lock_hold: blocked=%0d bad=%0d expected 16 0", blocked, bad_lock);
    end
    cyc(1, 0, 32'h50, 1, 1, 32'h400, 1, 0);
    n_checks++;
    if (core_gnt !== 1'b1 || lock_broken !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_break: core_gnt=%b lock_broken=%b expected 1 1", core_gnt, lock_broken);
    end
    for (int i = 18; i < 30; i++) begin
      cyc(1, 0, 32'h50, 1, 1, 32'h400, 1, 0);
      exp_c = ((i - 17) % 2) == 0;
      if (core_gnt !== exp_c || dbg_gnt !== ~exp_c || lock_broken !== 1'b0) bad_alt++;
    end
    n_checks++;
    if (bad_alt !== 0) begin
      n_fail++;
      $display("FAIL lock_ignored_after_break: %0d bad cycles expected 0", bad_alt);
    end
    cyc(1, 0, 32'h50, 1, 1, 32'h400, 0, 0);   // lock drops: rearms, debug wins
    cyc(1, 0, 32'h50, 1, 1, 32'h400, 1, 0);   // core wins
    cyc(1, 0, 32'h50, 1, 1, 32'h400, 1, 0);   // debug wins and relocks
    cyc(1, 0, 32'h50, 1, 1, 32'h400, 1, 0);
    n_checks++;
    if (core_gnt !== 1'b0 || dbg_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_reentry: core_gnt=%b dbg_gnt=%b expected 0 1", core_gnt, dbg_gnt);
    end
    cyc(1, 0, 32'h50, 1, 1, 32'h400, 0, 0);   // release, still LOCK this cycle
    cyc(1, 0, 32'h50, 1, 1, 32'h400, 0, 0);
    n_checks++;
    if (core_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_release: core_gnt=%b dbg_gnt=%b expected 1 0", core_gnt, dbg_gnt);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [5:0] during;
    do_reset();
    cyc(1, 0, 32'h60, 1, 0, 32'h64, 0, 0);   // core wins, then debug
    cyc(0, 0, 0, 1, 0, 32'h64, 0, 0);
    n_checks++;
    if (dbg_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_read_gnt: dbg_gnt=%b expected 1", dbg_gnt);
    end
    #1 reset = 1'b1;                          // before the edge that would launch rvalid
    during = '0;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 32'h60, 1, 0, 32'h64, 0, 32'h77);
      during = during | {core_gnt, dbg_gnt, mem_en, core_rvalid, dbg_rvalid, lock_broken};
    end
    n_checks++;
    if (during !== 6'b0) begin
      n_fail++;
      $display("FAIL in_reset_quiet: got %b expected 000000", during);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (core_gnt !== 1'b1 || dbg_gnt !== 1'b0 || dbg_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_conflict: cgnt=%b dgnt=%b drv=%b expected 1 0 0",
               core_gnt, dbg_gnt, dbg_rvalid);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h88);
    n_checks++;
    if (dbg_rvalid !== 1'b0 || core_rvalid !== 1'b1 || core_rdata !== 32'h88) begin
      n_fail++;
      $display("FAIL no_reissue: drv=%b crv=%b crd=%h expected 0 1 88",
               dbg_rvalid, core_rvalid, core_rdata);
    end
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, 32'h70, 1, 0, 32'h74, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (conflict_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL conflict_cnt_5: got %0d expected 5", conflict_cnt);
    end
    // Each 21-cycle round: 16 locked stalls plus at least one round-robin loss.
    for (int r = 0; r < 3900; r++) begin
      for (int k = 0; k < 20; k++) cyc(1, 0, 32'h70, 1, 0, 32'h74, 1, 0);
      cyc(1, 0, 32'h70, 1, 0, 32'h74, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL conflict_cnt_sat: got %h expected ffff", conflict_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_funct3 = '0;
    dbg_lock = 0; mem_rdata = '0;
    test_reset();
    test_core_load();
    test_round_robin();
    test_back_to_back();
    test_lock();
    test_reset_mid_read();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
